// File: rtl/pir_sample_filter_pkg.sv
// pir_pkg: shared constants and FSM state type for the PIR sample filter
// and the downstream motion controller.
//   PIR_SAMPLE_W : sample / threshold width shared with the controller
//   PIR_SAT_MAX  : clamp ceiling for raw PIR readings
//   pf_state_e   : filter FSM states (PF_WARMUP, PF_RUN)
package pir_pkg;

    localparam int unsigned PIR_SAMPLE_W = 7;
    localparam int unsigned PIR_SAT_MAX  = 100;

    typedef enum logic {
        PF_WARMUP = 1'b0,
        PF_RUN    = 1'b1
    } pf_state_e;

endpackage

// File: rtl/pir_sample_filter_if.sv
// pir_sample_filter_if: bundles the filter's control, sample and result
// signals.
//   master : drives enable, sample_valid, raw_1..3; observes results
//   slave  : the filter; consumes samples, drives pir_sensor_1..3,
//            filt_ready and stuck_fault
interface pir_sample_filter_if #(
    parameter int unsigned WIDTH = pir_pkg::PIR_SAMPLE_W
) ();

    logic             enable;
    logic             sample_valid;
    logic [WIDTH-1:0] raw_1;
    logic [WIDTH-1:0] raw_2;
    logic [WIDTH-1:0] raw_3;
    logic [WIDTH-1:0] pir_sensor_1;
    logic [WIDTH-1:0] pir_sensor_2;
    logic [WIDTH-1:0] pir_sensor_3;
    logic             filt_ready;
    logic [2:0]       stuck_fault;

    modport master (
        output enable, sample_valid, raw_1, raw_2, raw_3,
        input  pir_sensor_1, pir_sensor_2, pir_sensor_3, filt_ready, stuck_fault
    );

    modport slave (
        input  enable, sample_valid, raw_1, raw_2, raw_3,
        output pir_sensor_1, pir_sensor_2, pir_sensor_3, filt_ready, stuck_fault
    );

endinterface

// File: rtl/pir_chan_avg.sv
// pir_chan_avg: one PIR channel's conditioning datapath.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear_i     : synchronous clear of all channel state
//   accept_i    : a sample is taken this cycle
//   load_out_i  : the averaged output register loads on this accept
//   raw_i       : raw reading
//   avg_o       : registered average (0 while stuck)
//   stuck_o     : sticky stuck-sensor flag
module pir_chan_avg
    import pir_pkg::*;
#(
    parameter int unsigned WIDTH       = PIR_SAMPLE_W,
    parameter int unsigned WINDOW_LOG2 = 2,
    parameter int unsigned SAT_MAX     = PIR_SAT_MAX,
    parameter int unsigned STUCK_LIMIT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             accept_i,
    input  logic             load_out_i,
    input  logic [WIDTH-1:0] raw_i,
    output logic [WIDTH-1:0] avg_o,
    output logic             stuck_o
);

    localparam int unsigned DEPTH = 1 << WINDOW_LOG2;
    localparam int unsigned SUM_W = WIDTH + WINDOW_LOG2;
    localparam int unsigned CNT_W = (STUCK_LIMIT > 2) ? $clog2(STUCK_LIMIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STUCK_LIMIT - 1);

    // hist_q[0] is the newest sample, hist_q[DEPTH-1] the oldest
    logic [WIDTH-1:0] hist_q [DEPTH];
    logic [WIDTH-1:0] hist_d [DEPTH];
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] avg_q, avg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stuck_q, stuck_d;
    // hist_q[0] only counts as a previous sample once one has been taken
    logic             have_prev_q, have_prev_d;

    logic [WIDTH-1:0] clamped;
    logic [SUM_W-1:0] sum_next;

    assign clamped  = (raw_i > WIDTH'(SAT_MAX)) ? WIDTH'(SAT_MAX) : raw_i;
    assign sum_next = sum_q - SUM_W'(hist_q[DEPTH-1]) + SUM_W'(clamped);

    always_comb begin
        hist_d      = hist_q;
        sum_d       = sum_q;
        avg_d       = avg_q;
        cnt_d       = cnt_q;
        stuck_d     = stuck_q;
        have_prev_d = have_prev_q;
        if (clear_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                hist_d[i] = '0;
            end
            sum_d       = '0;
            avg_d       = '0;
            cnt_d       = '0;
            stuck_d     = 1'b0;
            have_prev_d = 1'b0;
        end else if (accept_i) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                hist_d[i] = hist_q[i-1];
            end
            hist_d[0]   = clamped;
            sum_d       = sum_next;
            have_prev_d = 1'b1;
            if (have_prev_q && (clamped == hist_q[0])) begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            end else begin
                cnt_d = '0;
            end
            stuck_d = stuck_q | (cnt_d == CNT_MAX);
            // A flag set on this same edge already blanks the output
            if (load_out_i) begin
                avg_d = stuck_d ? '0 : WIDTH'(sum_next >> WINDOW_LOG2);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                hist_q[i] <= '0;
            end
            sum_q       <= '0;
            avg_q       <= '0;
            cnt_q       <= '0;
            stuck_q     <= 1'b0;
            have_prev_q <= 1'b0;
        end else begin
            hist_q      <= hist_d;
            sum_q       <= sum_d;
            avg_q       <= avg_d;
            cnt_q       <= cnt_d;
            stuck_q     <= stuck_d;
            have_prev_q <= have_prev_d;
        end
    end

    assign avg_o   = avg_q;
    assign stuck_o = stuck_q;

endmodule

// File: rtl/pir_sample_filter.sv
// pir_sample_filter: saturating moving-average filter for three PIR
// channels feeding the motion controller.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pir_sample_filter_if slave (enable, sample_valid,
//                raw_1..3 in; pir_sensor_1..3, filt_ready, stuck_fault out)
// The FSM holds outputs at zero until the first full window is in.
module pir_sample_filter
    import pir_pkg::*;
#(
    parameter int unsigned WIDTH       = PIR_SAMPLE_W,
    parameter int unsigned WINDOW_LOG2 = 2,
    parameter int unsigned SAT_MAX     = PIR_SAT_MAX,
    parameter int unsigned STUCK_LIMIT = 64
) (
    input logic                clk,
    input logic                rst_n,
    pir_sample_filter_if.slave bus
);

    localparam int unsigned FILL_W = WINDOW_LOG2 + 1;
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'((1 << WINDOW_LOG2) - 1);

    pf_state_e         state_q, state_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              ready_q, ready_d;
    logic              clear;
    logic              accept;
    logic              load_out;

    // enable low wins over any strobe in the same cycle
    assign clear  = ~bus.enable;
    assign accept = bus.enable & bus.sample_valid;

    always_comb begin
        state_d  = state_q;
        fill_d   = fill_q;
        ready_d  = ready_q;
        load_out = 1'b0;
        if (clear) begin
            state_d = PF_WARMUP;
            fill_d  = '0;
            ready_d = 1'b0;
        end else if (accept) begin
            case (state_q)
                PF_WARMUP: begin
                    if (fill_q == FILL_LAST) begin
                        state_d  = PF_RUN;
                        fill_d   = '0;
                        ready_d  = 1'b1;
                        load_out = 1'b1;
                    end else begin
                        fill_d = fill_q + 1'b1;
                    end
                end
                PF_RUN:  load_out = 1'b1;
                default: state_d = PF_WARMUP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PF_WARMUP;
            fill_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            ready_q <= ready_d;
        end
    end

    logic [2:0] stuck;

    pir_chan_avg #(
        .WIDTH      (WIDTH),
        .WINDOW_LOG2(WINDOW_LOG2),
        .SAT_MAX    (SAT_MAX),
        .STUCK_LIMIT(STUCK_LIMIT)
    ) u_chan_1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (clear),
        .accept_i  (accept),
        .load_out_i(load_out),
        .raw_i     (bus.raw_1),
        .avg_o     (bus.pir_sensor_1),
        .stuck_o   (stuck[0])
    );

    pir_chan_avg #(
        .WIDTH      (WIDTH),
        .WINDOW_LOG2(WINDOW_LOG2),
        .SAT_MAX    (SAT_MAX),
        .STUCK_LIMIT(STUCK_LIMIT)
    ) u_chan_2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (clear),
        .accept_i  (accept),
        .load_out_i(load_out),
        .raw_i     (bus.raw_2),
        .avg_o     (bus.pir_sensor_2),
        .stuck_o   (stuck[1])
    );

    pir_chan_avg #(
        .WIDTH      (WIDTH),
        .WINDOW_LOG2(WINDOW_LOG2),
        .SAT_MAX    (SAT_MAX),
        .STUCK_LIMIT(STUCK_LIMIT)
    ) u_chan_3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (clear),
        .accept_i  (accept),
        .load_out_i(load_out),
        .raw_i     (bus.raw_3),
        .avg_o     (bus.pir_sensor_3),
        .stuck_o   (stuck[2])
    );

    assign bus.filt_ready  = ready_q;
    assign bus.stuck_fault = stuck;

endmodule

// File: tb/tb_pir_sample_filter.sv
// tb_pir_sample_filter: directed plus randomized checks of the PIR sample
// filter against a window/run-length reference model.
module tb_pir_sample_filter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pir_sample_filter_if #(.WIDTH(7)) bus ();

    pir_sample_filter #(
        .WIDTH      (7),
        .WINDOW_LOG2(2),
        .SAT_MAX    (100),
        .STUCK_LIMIT(64)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: last four clamped samples, accepts since clear,
    // current run length of identical samples, sticky fault.
    int hist [3][4];
    int nacc;
    int last_s [3];
    int run_len [3];
    bit fault [3];

    function automatic void model_clear();
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < 4; k++) hist[c][k] = 0;
            last_s[c]  = 0;
            run_len[c] = 0;
            fault[c]   = 1'b0;
        end
        nacc = 0;
    endfunction

    function automatic void model_accept(input int r1, input int r2, input int r3);
        int r [3];
        int cl;
        r[0] = r1; r[1] = r2; r[2] = r3;
        for (int c = 0; c < 3; c++) begin
            cl = (r[c] > 100) ? 100 : r[c];
            if (nacc > 0 && cl == last_s[c]) run_len[c]++;
            else run_len[c] = 1;
            last_s[c] = cl;
            if (run_len[c] >= 64) fault[c] = 1'b1;
            for (int k = 3; k > 0; k--) hist[c][k] = hist[c][k-1];
            hist[c][0] = cl;
        end
        nacc++;
    endfunction

    function automatic int exp_out(input int c);
        if (nacc < 4 || fault[c]) return 0;
        return (hist[c][0] + hist[c][1] + hist[c][2] + hist[c][3]) / 4;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pir1"}, {25'd0, bus.pir_sensor_1}, 32'(exp_out(0)));
        check({tag, ".pir2"}, {25'd0, bus.pir_sensor_2}, 32'(exp_out(1)));
        check({tag, ".pir3"}, {25'd0, bus.pir_sensor_3}, 32'(exp_out(2)));
        check({tag, ".ready"}, {31'd0, bus.filt_ready}, 32'(nacc >= 4));
        check({tag, ".stuck"}, {29'd0, bus.stuck_fault}, {29'd0, fault[2], fault[1], fault[0]});
    endtask

    task automatic step(input bit en, input bit sv, input int r1, input int r2, input int r3,
                        input string tag);
        @(negedge clk);
        bus.enable       = en;
        bus.sample_valid = sv;
        bus.raw_1        = 7'(r1);
        bus.raw_2        = 7'(r2);
        bus.raw_3        = 7'(r3);
        @(posedge clk);
        #1;
        if (!en) model_clear();
        else if (sv) model_accept(r1, r2, r3);
        check_all(tag);
    endtask

    int mode [3];
    int hv [3];
    int rr [3];
    int r1v [4] = '{40, 40, 40, 80};
    int r2v [4] = '{101, 100, 100, 99};

    initial begin
        bus.enable = 1'b0; bus.sample_valid = 1'b0;
        bus.raw_1 = '0; bus.raw_2 = '0; bus.raw_3 = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check("reset.pir1", {25'd0, bus.pir_sensor_1}, 32'd0);
        check("reset.ready", {31'd0, bus.filt_ready}, 32'd0);
        check("reset.stuck", {29'd0, bus.stuck_fault}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Warm-up: 40,40,40,80 on channel 1
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, r1v[i], 10 * (i + 1), 5 + i, "warm");
            if (i < 3) begin
                check("warm.pir1_zero", {25'd0, bus.pir_sensor_1}, 32'd0);
                check("warm.ready_low", {31'd0, bus.filt_ready}, 32'd0);
            end
        end
        check("warm.pir1_50", {25'd0, bus.pir_sensor_1}, 32'd50);
        check("warm.ready_high", {31'd0, bus.filt_ready}, 32'd1);

        // Saturation then floor
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 3 * i + 1, 127, 30 + i, "sat");
        check("sat.pir2_100", {25'd0, bus.pir_sensor_2}, 32'd100);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 3 * i + 2, r2v[i], 40 + i, "floor");
        check("floor.pir2_99", {25'd0, bus.pir_sensor_2}, 32'd99);

        // Stuck detection on channel 3
        for (int i = 0; i < 63; i++) step(1'b1, 1'b1, i % 50, (i * 7) % 101, 20, "stuckrun");
        check("stuck.63_clear", {29'd0, bus.stuck_fault}, 32'd0);
        check("stuck.63_pir3", {25'd0, bus.pir_sensor_3}, 32'd20);
        step(1'b1, 1'b1, 55, 44, 20, "stuck64");
        check("stuck.64_flag", {29'd0, bus.stuck_fault}, 32'd4);
        check("stuck.64_pir3", {25'd0, bus.pir_sensor_3}, 32'd0);
        step(1'b1, 1'b1, 56, 45, 21, "stuckdiff");
        check("stuck.sticky", {31'd0, bus.stuck_fault[2]}, 32'd1);

        // Enable drop
        step(1'b0, 1'b0, 0, 0, 0, "endrop");
        check("endrop.pir1", {25'd0, bus.pir_sensor_1}, 32'd0);
        check("endrop.ready", {31'd0, bus.filt_ready}, 32'd0);
        check("endrop.stuck", {29'd0, bus.stuck_fault}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 70 + i, 60 + i, 50 + i, "reen");
            check("reen.pir1_zero", {25'd0, bus.pir_sensor_1}, 32'd0);
        end
        step(1'b1, 1'b1, 73, 63, 53, "reen4");
        check("reen4.pir1", {25'd0, bus.pir_sensor_1}, 32'd71);

        // Strobe with enable low is discarded
        step(1'b0, 1'b1, 90, 90, 90, "override");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 10 + i, 20 + i, 30 + i, "ovr_fill");
        check("override.ready_low", {31'd0, bus.filt_ready}, 32'd0);
        step(1'b1, 1'b1, 13, 23, 33, "ovr_fill4");
        check("override.ready_high", {31'd0, bus.filt_ready}, 32'd1);

        // Randomized phase
        for (int it = 0; it < 2000; it++) begin
            if (it % 100 == 0) begin
                for (int c = 0; c < 3; c++) begin
                    mode[c] = int'($urandom_range(0, 1));
                    hv[c]   = int'($urandom_range(0, 127));
                end
            end
            for (int c = 0; c < 3; c++) begin
                rr[c] = (mode[c] != 0) ? hv[c] : int'($urandom_range(0, 127));
            end
            step($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0,
                 rr[0], rr[1], rr[2], "rand");
        end

        // Asynchronous reset mid-cycle in RUN
        step(1'b0, 1'b0, 0, 0, 0, "pre_rst_clr");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 60 + i, 61 + i, 62 + i, "pre_rst");
        step(1'b1, 1'b0, 0, 0, 0, "pre_rst_idle");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.pir1", {25'd0, bus.pir_sensor_1}, 32'd0);
        check("arst.pir3", {25'd0, bus.pir_sensor_3}, 32'd0);
        check("arst.ready", {31'd0, bus.filt_ready}, 32'd0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b1, 9, 9, 9, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
